// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte producers.
// Round-robin arbitration in IDLE, a one-cycle start pulse to the UART, then
// it waits for done and holds an idle-line gap counted in s_tick pulses.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   s_tick              baud oversampling tick (one clk wide)
//   req0_valid/data     pixel result stream byte; req0_ready = accepted
//   req1_valid/data     status/echo byte;         req1_ready = accepted
//   tx_start, tx_data   start pulse and byte to the UART TX (registered)
//   tx_done_tick        UART TX finished the stop bit
//   grant_id            requester of the current or last transfer
//   busy                high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned GAP_TICKS = 16,
    parameter int unsigned GW        = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            req0_valid,
    input  logic [DBIT-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DBIT-1:0] req1_data,
    output logic            req1_ready,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_data,
    input  logic            tx_done_tick,
    output logic            grant_id,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Terminal gap count; unused when the gap is disabled.
    localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS != 0) ? GW'(GAP_TICKS - 1) : '0;

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic            last;
    logic            grant_valid;
    logic            grant_sel;

    // Round-robin grant: a lone requester wins; on contention the one not served last.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_sel   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
        req0_ready = (state == IDLE) && grant_valid && !grant_sel;
        req1_ready = (state == IDLE) && grant_valid && grant_sel;
    end

    // Transfer sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= 1'b0;
            busy     <= 1'b0;
            gap_cnt  <= '0;
            last     <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state    <= START;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        tx_data  <= grant_sel ? req1_data : req0_data;
                        grant_id <= grant_sel;
                        last     <= grant_sel;
                    end
                end
                START: begin
                    // A done tick here belongs to no transfer of ours; ignore it.
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done_tick) begin
                        gap_cnt <= '0;
                        if (GAP_TICKS != 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (s_tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run checked
// against an event-counting reference model. dut_a has a 16-tick gap,
// dut_b has the gap disabled.
module tb_uart_tx_arbiter;

    localparam int unsigned GAPA = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_s_tick = 0, a_v0 = 0, a_v1 = 0, a_done = 0;
    logic [7:0] a_d0 = 0, a_d1 = 0;
    logic       a_r0, a_r1, a_start, a_gid, a_busy;
    logic [7:0] a_txd;

    logic       b_s_tick = 0, b_v0 = 0, b_v1 = 0, b_done = 0;
    logic [7:0] b_d0 = 0, b_d1 = 0;
    logic       b_r0, b_r1, b_start, b_gid, b_busy;
    logic [7:0] b_txd;

    int errors = 0;
    int checks = 0;
    int a_nstart = 0;

    uart_tx_arbiter #(.DBIT(8), .GAP_TICKS(GAPA), .GW(5)) dut_a (
        .clk(clk), .reset(reset), .s_tick(a_s_tick),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .tx_start(a_start), .tx_data(a_txd), .tx_done_tick(a_done),
        .grant_id(a_gid), .busy(a_busy)
    );

    uart_tx_arbiter #(.DBIT(8), .GAP_TICKS(0), .GW(5)) dut_b (
        .clk(clk), .reset(reset), .s_tick(b_s_tick),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .tx_start(b_start), .tx_data(b_txd), .tx_done_tick(b_done),
        .grant_id(b_gid), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (a_start) a_nstart++;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        a_s_tick = 0; a_v0 = 0; a_v1 = 0; a_done = 0; a_d0 = 0; a_d1 = 0;
        b_s_tick = 0; b_v0 = 0; b_v1 = 0; b_done = 0; b_d0 = 0; b_d1 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) cyc();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", a_start); end
        checks++; if (a_txd !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", a_txd); end
        checks++; if (a_gid !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %b expected 0", a_gid); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b expected 0", b_busy); end
        reset = 1'b0;
    endtask

    // Single req0 byte, spurious done in START, s_ticks in WAIT_DONE, exact gap length.
    task automatic test_single();
        int n0;
        cyc();
        #1 n0 = a_nstart;
        a_v0 = 1; a_d0 = 8'hA5;
        #1;
        checks++; if (a_r0 !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b expected 1", a_r0); end
        checks++; if (a_r1 !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b expected 0", a_r1); end
        cyc();
        checks++; if (a_start !== 1'b1) begin errors++; $display("FAIL single_tx_start: got %b expected 1", a_start); end
        checks++; if (a_txd !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h expected a5", a_txd); end
        checks++; if (a_gid !== 1'b0) begin errors++; $display("FAIL single_grant_id: got %b expected 0", a_gid); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", a_busy); end
        a_d0 = 8'h5A; a_done = 1; a_s_tick = 1;
        #1;
        checks++; if (a_r0 !== 1'b0) begin errors++; $display("FAIL single_ready_in_start: got %b expected 0", a_r0); end
        cyc();
        a_done = 0;
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", a_start); end
        repeat (20) cyc();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_wait_hold: busy got %b expected 1", a_busy); end
        a_s_tick = 0; a_v0 = 0;
        a_done = 1;
        cyc();
        a_done = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc(); cyc();
            a_s_tick = 1;
            cyc();
            a_s_tick = 0;
            if (k == 15) begin
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_gap_15: busy got %b expected 1", a_busy); end
            end
            if (k == 16) begin
                checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_gap_16: busy got %b expected 0", a_busy); end
            end
        end
        #1;
        checks++; if (a_nstart - n0 !== 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", a_nstart - n0); end
    endtask

    // Gap measured with a realistic s_tick period of 651 clocks.
    task automatic test_gap_timing();
        int early;
        do_reset();
        a_v1 = 1; a_d1 = 8'h3C;
        cyc();
        a_v1 = 0;
        checks++; if (a_txd !== 8'h3C || a_gid !== 1'b1) begin errors++; $display("FAIL gap_first: got %h/%b expected 3c/1", a_txd, a_gid); end
        cyc(); cyc();
        a_done = 1;
        cyc();
        a_done = 0;
        a_v0 = 1; a_d0 = 8'h77;
        early = 0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 651; j++) begin
                if (j != 0 || k != 0) cyc();
                a_s_tick = (j == 650);
                #1 if (a_r0) early++;
            end
        end
        cyc();
        a_s_tick = 0;
        #1;
        checks++; if (early !== 0) begin errors++; $display("FAIL gap_early_ready: got %0d cycles expected 0", early); end
        checks++; if (a_r0 !== 1'b1) begin errors++; $display("FAIL gap_ready_after: got %b expected 1", a_r0); end
        cyc();
        a_v0 = 0;
        checks++; if (a_start !== 1'b1 || a_txd !== 8'h77 || a_gid !== 1'b0) begin
            errors++; $display("FAIL gap_next_byte: got %b/%h/%b expected 1/77/0", a_start, a_txd, a_gid);
        end
    endtask

    // Both requesters continuously valid: strict alternation 0,1,0,1.
    task automatic test_contention();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] exp_seq[4];
        logic       found, g;
        do_reset();
        q0 = '{8'h11, 8'h33};
        q1 = '{8'h22, 8'h44};
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        a_s_tick = 1;
        a_v0 = 1; a_d0 = q0[0];
        a_v1 = 1; a_d1 = q1[0];
        for (int n = 0; n < 4; n++) begin
            found = 0; g = 0;
            for (int t = 0; t < 100; t++) begin
                #1;
                if (a_r0 || a_r1) begin found = 1; g = a_r1; break; end
                cyc();
            end
            checks++;
            if (!found) begin errors++; $display("FAIL contention_timeout: byte %0d got none expected handshake", n); end
            else begin
                if (g) void'(q1.pop_front()); else void'(q0.pop_front());
                cyc();
                if (a_start !== 1'b1 || a_txd !== exp_seq[n] || a_gid !== 1'(n % 2)) begin
                    errors++;
                    $display("FAIL contention_byte%0d: got %b/%h/%b expected 1/%h/%0d", n, a_start, a_txd, a_gid, exp_seq[n], n % 2);
                end
                a_v0 = (q0.size() > 0); if (q0.size() > 0) a_d0 = q0[0];
                a_v1 = (q1.size() > 0); if (q1.size() > 0) a_d1 = q1[0];
                cyc(); cyc();
                a_done = 1;
                cyc();
                a_done = 0;
            end
        end
        a_s_tick = 0; a_v0 = 0; a_v1 = 0;
    endtask

    // Gap disabled: done returns to IDLE next cycle, queued req1 is served at once.
    task automatic test_gap0();
        do_reset();
        b_v0 = 1; b_d0 = 8'h66;
        cyc();
        b_v0 = 0;
        checks++; if (b_start !== 1'b1 || b_txd !== 8'h66) begin errors++; $display("FAIL gap0_first: got %b/%h expected 1/66", b_start, b_txd); end
        b_v1 = 1; b_d1 = 8'h99;
        cyc(); cyc();
        b_done = 1;
        #1;
        checks++; if (b_r1 !== 1'b0) begin errors++; $display("FAIL gap0_ready_in_wait: got %b expected 0", b_r1); end
        cyc();
        b_done = 0;
        #1;
        checks++; if (b_r1 !== 1'b1 || b_busy !== 1'b0) begin errors++; $display("FAIL gap0_ready_next: got %b/%b expected 1/0", b_r1, b_busy); end
        cyc();
        b_v1 = 0;
        checks++; if (b_start !== 1'b1 || b_txd !== 8'h99 || b_gid !== 1'b1) begin
            errors++; $display("FAIL gap0_second: got %b/%h/%b expected 1/99/1", b_start, b_txd, b_gid);
        end
    endtask

    // Asynchronous reset while waiting for done; req0 wins again afterwards.
    task automatic test_reset_mid();
        do_reset();
        a_v0 = 1; a_d0 = 8'hC3; a_v1 = 1; a_d1 = 8'h3C;
        cyc();
        checks++; if (a_txd !== 8'hC3 || a_gid !== 1'b0) begin errors++; $display("FAIL mid_first: got %h/%b expected c3/0", a_txd, a_gid); end
        cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        checks++; if (a_busy !== 1'b0 || a_start !== 1'b0 || a_txd !== 8'h00 || a_gid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_values: got %b/%b/%h/%b expected 0/0/00/0", a_busy, a_start, a_txd, a_gid);
        end
        cyc(); cyc();
        reset = 1'b0;
        #1;
        checks++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0) begin errors++; $display("FAIL mid_regrant: got %b/%b expected 1/0", a_r0, a_r1); end
        cyc();
        a_v0 = 0; a_v1 = 0;
        checks++; if (a_start !== 1'b1 || a_txd !== 8'hC3 || a_gid !== 1'b0) begin
            errors++; $display("FAIL mid_after: got %b/%h/%b expected 1/c3/0", a_start, a_txd, a_gid);
        end
    endtask

    // Random traffic against a model built from event counts, not states.
    task automatic test_random();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic       m_free, m_last, m_done_seen, exp_gid, gv, g, e0, e1;
        logic [7:0] exp_data;
        int         m_age, m_ticks, ntx;
        do_reset();
        m_free = 1; m_last = 1; m_done_seen = 0; exp_gid = 0; exp_data = 8'h00;
        m_age = 0; m_ticks = 0; ntx = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            checks++; if (a_start !== (!m_free && m_age == 1)) begin errors++; $display("FAIL rnd_tx_start@%0d: got %b expected %b", i, a_start, !m_free && m_age == 1); end
            checks++; if (a_busy !== !m_free) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", i, a_busy, !m_free); end
            checks++; if (a_txd !== exp_data) begin errors++; $display("FAIL rnd_tx_data@%0d: got %h expected %h", i, a_txd, exp_data); end
            checks++; if (a_gid !== exp_gid) begin errors++; $display("FAIL rnd_grant_id@%0d: got %b expected %b", i, a_gid, exp_gid); end
            if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(8'($urandom));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(8'($urandom));
            a_v0 = (q0.size() > 0) && ($urandom_range(0, 4) != 0);
            a_d0 = (q0.size() > 0) ? q0[0] : 8'($urandom);
            a_v1 = (q1.size() > 0) && ($urandom_range(0, 4) != 0);
            a_d1 = (q1.size() > 0) ? q1[0] : 8'($urandom);
            a_s_tick = ($urandom_range(0, 2) == 0);
            a_done = (!m_free && !m_done_seen && m_age >= 2 && $urandom_range(0, 3) == 0)
                  || (!m_free && m_age == 1 && $urandom_range(0, 2) == 0);
            #1;
            gv = a_v0 || a_v1;
            g  = (a_v0 && a_v1) ? !m_last : !a_v0;
            e0 = m_free && gv && !g;
            e1 = m_free && gv && g;
            checks++; if (a_r0 !== e0) begin errors++; $display("FAIL rnd_ready0@%0d: got %b expected %b", i, a_r0, e0); end
            checks++; if (a_r1 !== e1) begin errors++; $display("FAIL rnd_ready1@%0d: got %b expected %b", i, a_r1, e1); end
            if (m_free) begin
                if (gv) begin
                    exp_data = g ? q1.pop_front() : q0.pop_front();
                    exp_gid = g; m_last = g; m_free = 0; m_age = 1; m_done_seen = 0; ntx++;
                end
            end else begin
                if (!m_done_seen && m_age >= 2 && a_done) begin
                    m_done_seen = 1; m_ticks = 0;
                    if (GAPA == 0) m_free = 1;
                end else if (m_done_seen && a_s_tick) begin
                    m_ticks++;
                    if (m_ticks == GAPA) m_free = 1;
                end
                if (m_age < 100000) m_age++;
            end
        end
        checks++; if (ntx < 20) begin errors++; $display("FAIL rnd_throughput: got %0d transfers expected at least 20", ntx); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_timing();
        test_contention();
        test_gap0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
